// File: rtl/spi_master_byte.sv
// ---------------------------------------------------------------------------
// spi_master_byte
//
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// The host side is a valid/ready byte stream. Consecutive bytes of one frame
// keep chip select low. A byte flagged as last raises chip select after it
// and then holds a minimum deselect gap.
//
// MISO is sampled on the clock edge that raises SCK. MOSI changes on the
// edge that lowers SCK. This matches a slave that shifts MISO on the SCK
// negedge and samples MOSI on the SCK posedge.
//
// Parameters
//   CLK_DIV     clk_i cycles per SCK half-period (legal range 2..255)
//
// Ports
//   clk_i       system clock, all registers on its rising edge
//   rst_i       synchronous reset, active-high
//   tx_data_i   byte to send, MSB first
//   tx_last_i   1 = raise CS after this byte (end of frame)
//   tx_valid_i  tx_data_i / tx_last_i valid
//   tx_ready_o  byte accepted when tx_valid_i & tx_ready_o
//   rx_data_o   byte shifted in from MISO, stable until the next rx_valid_o
//   rx_valid_o  one-cycle pulse when rx_data_o is updated
//   busy_o      1 whenever the master is not idle
//   spi_sck_o   SPI clock, idles low
//   spi_mosi_o  SPI data out
//   spi_miso_i  SPI data in (asynchronous)
//   spi_cs_o    chip select, active low
// ---------------------------------------------------------------------------
module spi_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic       spi_cs_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        WAIT,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_shift;
    logic [7:0] rx_shift;
    logic       last_byte;
    logic       final_phase;
    logic       div_done;
    logic       accept;

    assign div_done   = (div_cnt == 8'd0);
    assign tx_ready_o = (state == IDLE) || (state == WAIT);
    assign busy_o     = (state != IDLE);
    assign accept     = tx_valid_i && tx_ready_o;

    // Whole master in one registered FSM, so every SPI pin comes from a flop.
    // The divider counts DIV_LOAD..0 and each timed phase ends on the cycle it
    // reads 0. Each phase entry reloads it. Outside timed phases it rests at 0.
    // MISO goes straight into the rx shifter on the edge that raises SCK.
    // That shifter is its only sampling point.
    // final_phase marks the low phase after bit 7. bit_cnt alone cannot tell
    // it apart from the low phase after bit 6, because both see bit_cnt == 7.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            spi_cs_o    <= 1'b1;
            spi_sck_o   <= 1'b0;
            spi_mosi_o  <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            bit_cnt     <= 3'd0;
            div_cnt     <= 8'd0;
            tx_shift    <= 7'd0;
            rx_shift    <= 8'h00;
            last_byte   <= 1'b0;
            final_phase <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (!div_done) begin
                div_cnt <= div_cnt - 8'd1;
            end

            case (state)
                IDLE, WAIT: begin
                    if (accept) begin
                        tx_shift    <= tx_data_i[6:0];
                        last_byte   <= tx_last_i;
                        spi_cs_o    <= 1'b0;
                        spi_mosi_o  <= tx_data_i[7];
                        bit_cnt     <= 3'd0;
                        final_phase <= 1'b0;
                        div_cnt     <= DIV_LOAD;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    if (div_done) begin
                        spi_sck_o <= 1'b1;
                        rx_shift  <= {rx_shift[6:0], spi_miso_i};
                        div_cnt   <= DIV_LOAD;
                        state     <= HIGH;
                    end
                end

                HIGH: begin
                    if (div_done) begin
                        spi_sck_o <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        state     <= LOW;
                        if (bit_cnt != 3'd7) begin
                            spi_mosi_o <= tx_shift[6];
                            tx_shift   <= {tx_shift[5:0], 1'b0};
                            bit_cnt    <= bit_cnt + 3'd1;
                        end else begin
                            rx_data_o   <= rx_shift;
                            rx_valid_o  <= 1'b1;
                            final_phase <= 1'b1;
                        end
                    end
                end

                LOW: begin
                    if (div_done) begin
                        if (!final_phase) begin
                            spi_sck_o <= 1'b1;
                            rx_shift  <= {rx_shift[6:0], spi_miso_i};
                            div_cnt   <= DIV_LOAD;
                            state     <= HIGH;
                        end else if (last_byte) begin
                            spi_cs_o   <= 1'b1;
                            spi_mosi_o <= 1'b0;
                            div_cnt    <= DIV_LOAD;
                            state      <= GAP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                GAP: begin
                    if (div_done) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
